// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: ID/EX bundle
// layout (widths and LSB offsets), bundle sizes, NOP control and the
// occupancy-state decode used by the stage control logic.
package pipe_pkg;

  // ID/EX data bundle fields, packed LSB-first: shamt at bit 0, pc on top.
  localparam int SHAMT_W   = 5;
  localparam int FUNC_W    = 6;
  localparam int RT_W      = 5;
  localparam int RD_W      = 5;
  localparam int IMM_W     = 32;
  localparam int RD2_W     = 32;
  localparam int RD1_W     = 32;
  localparam int PC_W      = 32;

  localparam int SHAMT_LSB = 0;
  localparam int FUNC_LSB  = SHAMT_LSB + SHAMT_W;
  localparam int RT_LSB    = FUNC_LSB + FUNC_W;
  localparam int RD_LSB    = RT_LSB + RT_W;
  localparam int IMM_LSB   = RD_LSB + RD_W;
  localparam int RD2_LSB   = IMM_LSB + IMM_W;
  localparam int RD1_LSB   = RD2_LSB + RD2_W;
  localparam int PC_LSB    = RD1_LSB + RD1_W;

  localparam int ID_EX_DATA_W = PC_LSB + PC_W;  // 149

  // ID/EX control bundle fields, packed LSB-first.
  localparam int MEMTOREG_W   = 2;
  localparam int MEMREAD_W    = 1;
  localparam int MEMWRITE_W   = 1;
  localparam int ALUOP_W      = 5;
  localparam int REGWRITE_W   = 1;
  localparam int REGDST_W     = 2;
  localparam int ALUSRC_W     = 1;

  localparam int MEMTOREG_LSB = 0;
  localparam int MEMREAD_LSB  = MEMTOREG_LSB + MEMTOREG_W;
  localparam int MEMWRITE_LSB = MEMREAD_LSB + MEMREAD_W;
  localparam int ALUOP_LSB    = MEMWRITE_LSB + MEMWRITE_W;
  localparam int REGWRITE_LSB = ALUOP_LSB + ALUOP_W;
  localparam int REGDST_LSB   = REGWRITE_LSB + REGWRITE_W;
  localparam int ALUSRC_LSB   = REGDST_LSB + REGDST_W;

  localparam int ID_EX_CTRL_W = ALUSRC_LSB + ALUSRC_W;  // 13

  // An empty slot presents this control word, which writes nothing downstream.
  localparam logic [ID_EX_CTRL_W-1:0] NOP_CTRL = '0;

  // Stage occupancy as seen by the control logic, keyed on (m_valid, s_valid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  function automatic stage_state_e decode_state(input logic m_valid, input logic s_valid);
    if (s_valid)      return ST_FULL;
    else if (m_valid) return ST_ONE;
    else              return ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One holding slot: data and control registers plus a valid bit.
// clear_i drops valid and zeroes control but keeps data; clear wins over load.
module pipe_slot #(
  parameter int DATA_W = 8,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Next-state: clear squashes valid/control, otherwise load captures a beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  // Slot registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
//
// Handshake: a beat moves upstream->stage when in_valid && in_ready and
// stage->downstream when out_valid && out_ready, both on the rising edge.
// in_valid/in_data/in_ctrl must stay stable until accepted; out_valid never
// drops without a fire-out, flush or reset. With SKID=1 in_ready depends only
// on held state and flush, never on out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data, m_data_d;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d;
  logic              fire_in, fire_out;
  logic              m_load_in, m_load_s, m_clear, s_load, s_clear, m_load;
  stage_state_e      state;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign state    = decode_state(m_valid, s_valid);
  assign fire_in  = in_valid && in_ready;
  assign fire_out = m_valid && out_ready;

  // Slot control decoded from occupancy state; flush overrides everything.
  always_comb begin
    m_load_in = 1'b0;
    m_load_s  = 1'b0;
    m_clear   = 1'b0;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (fire_in) m_load_in = 1'b1;
        end
        ST_ONE: begin
          if (fire_in && fire_out) m_load_in = 1'b1;
          else if (fire_in)        s_load    = 1'b1;
          else if (fire_out)       m_clear   = 1'b1;
        end
        ST_FULL: begin
          if (fire_out) begin
            m_load_s = 1'b1;
            s_clear  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Main slot refills from the skid slot when draining, else from upstream.
  assign m_load   = m_load_in || m_load_s;
  assign m_data_d = m_load_s ? s_data : in_data;
  assign m_ctrl_d = m_load_s ? s_ctrl : in_ctrl;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_m_slot (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (m_load),
    .clear_i (m_clear),
    .data_i  (m_data_d),
    .ctrl_i  (m_ctrl_d),
    .valid_o (m_valid),
    .data_o  (m_data),
    .ctrl_o  (m_ctrl)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_s_slot (
      .clk_i   (clk),
      .rst_i   (reset),
      .load_i  (s_load),
      .clear_i (s_clear),
      .data_i  (in_data),
      .ctrl_i  (in_ctrl),
      .valid_o (s_valid),
      .data_o  (s_data),
      .ctrl_o  (s_ctrl)
    );
    // Registered ready: only a full skid slot (or flush) blocks upstream.
    assign in_ready = !s_valid && !flush;
  end else begin : g_noskid
    logic unused_skid_ctl;
    assign s_valid         = 1'b0;
    assign s_data          = '0;
    assign s_ctrl          = '0;
    assign unused_skid_ctl = s_load | s_clear;
    // Single register: accept when empty or when the held beat leaves now.
    assign in_ready = (!m_valid || out_ready) && !flush;
  end

  // Stall counter next-state: count blocked cycles, hold at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register; flush leaves it alone, only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : {CTRL_W{1'b0}};
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
  assign stall_cnt = stall_cnt_q;

endmodule
